receiver: RTL and testbench

- Downstream partner of the 16-bit sender on the Request/Ack four-phase link.
- Accepts each word the sender presents, acknowledges it, and stores it in a 16-entry FIFO.
- Exposes the stored words to a local consumer through a pop interface.
- Reports a pulse each time a complete 16-word block has been received.

---
 rtl/link_pkg.sv | 18 +
 rtl/sync_fifo.sv | 81 ++++++++
 rtl/receiver.sv | 116 +++++++++++
 tb/tb_receiver.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared constants and state encoding for the four-phase Request/Ack link.
package link_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int DEPTH      = 16;
    localparam int ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CAPTURE   = 2'd1,
        WAIT_DROP = 2'd2
    } rx_state_e;

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] ptr);
        return ptr + ADDR_WIDTH'(1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered head-of-queue read port and registered flags.
module sync_fifo
    import link_pkg::*;
#(
    parameter int P_DATA_WIDTH = DATA_WIDTH,
    parameter int P_DEPTH      = DEPTH,
    parameter int P_ADDR_WIDTH = ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_wr_en,
    input  logic [P_DATA_WIDTH-1:0] i_wr_data,
    input  logic                    i_rd_en,
    output logic [P_DATA_WIDTH-1:0] o_rd_data,
    output logic                    o_empty,
    output logic                    o_full,
    output logic [P_ADDR_WIDTH:0]   o_count
);

    logic [P_DATA_WIDTH-1:0] r_mem [P_DEPTH];
    logic [P_ADDR_WIDTH-1:0] r_wr_ptr;
    logic [P_ADDR_WIDTH-1:0] r_rd_ptr;
    logic [P_ADDR_WIDTH:0]   r_count;
    logic                    r_empty;
    logic                    r_full;
    logic [P_DATA_WIDTH-1:0] r_rd_data;
    logic                    w_wr;
    logic                    w_rd;
    logic [P_ADDR_WIDTH:0]   w_count_nxt;

    // Qualify requests against the current flags and compute next occupancy.
    always_comb begin
        w_wr        = i_wr_en & ~r_full;
        w_rd        = i_rd_en & ~r_empty;
        w_count_nxt = r_count;
        case ({w_wr, w_rd})
            2'b10:   w_count_nxt = r_count + (P_ADDR_WIDTH+1)'(1);
            2'b01:   w_count_nxt = r_count - (P_ADDR_WIDTH+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers, occupancy, flags and the registered head word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_rd_data <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_rd) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == (P_ADDR_WIDTH+1)'(0));
            r_full  <= (w_count_nxt == (P_ADDR_WIDTH+1)'(P_DEPTH));
            // Head word is held while empty so the consumer sees the last value.
            if (!r_empty) begin
                r_rd_data <= r_mem[r_rd_ptr];
            end
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_empty   = r_empty;
    assign o_full    = r_full;
    assign o_count   = r_count;

endmodule

// File: rtl/receiver.sv
// Four-phase link receiver: captures one word per Request phase into a FIFO,
// drives a registered Ack and pulses BlockDone after every DEPTH-th word.
module receiver
    import link_pkg::*;
#(
    parameter int P_DATA_WIDTH = DATA_WIDTH,
    parameter int P_DEPTH      = DEPTH,
    parameter int P_ADDR_WIDTH = ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic                    Request,
    input  logic [P_DATA_WIDTH-1:0] DataIn,
    output logic                    Ack,
    input  logic                    Pop,
    output logic [P_DATA_WIDTH-1:0] DataOut,
    output logic                    Empty,
    output logic                    Full,
    output logic [P_ADDR_WIDTH:0]   Count,
    output logic                    BlockDone
);

    rx_state_e               r_state;
    rx_state_e               w_state_nxt;
    logic                    r_ack;
    logic                    r_block_done;
    logic [P_ADDR_WIDTH-1:0] r_blk_cnt;
    logic                    w_wr_en;
    logic                    w_ack_nxt;
    logic                    w_full;

    // Link state register.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: one write per Request high phase, blocked while full.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (Request && !w_full) begin
                    w_state_nxt = CAPTURE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CAPTURE: w_state_nxt = WAIT_DROP;
            WAIT_DROP: begin
                if (Request) begin
                    w_state_nxt = WAIT_DROP;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode: write strobe and the value Ack takes at the next edge.
    always_comb begin
        w_wr_en   = 1'b0;
        w_ack_nxt = 1'b0;
        if ((r_state == IDLE) && Request && !w_full) begin
            w_wr_en = 1'b1;
        end else begin
            w_wr_en = 1'b0;
        end
        // Ack is high while the link sits in WAIT_DROP, i.e. one cycle after the write.
        if (w_state_nxt == WAIT_DROP) begin
            w_ack_nxt = 1'b1;
        end else begin
            w_ack_nxt = 1'b0;
        end
    end

    // Registered Ack, block counter and BlockDone pulse.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_ack        <= 1'b0;
            r_blk_cnt    <= '0;
            r_block_done <= 1'b0;
        end else begin
            r_ack        <= w_ack_nxt;
            r_block_done <= w_wr_en && (r_blk_cnt == P_ADDR_WIDTH'(P_DEPTH - 1));
            if (w_wr_en) begin
                r_blk_cnt <= ptr_inc(r_blk_cnt);
            end
        end
    end

    sync_fifo #(
        .P_DATA_WIDTH (P_DATA_WIDTH),
        .P_DEPTH      (P_DEPTH),
        .P_ADDR_WIDTH (P_ADDR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (Reset),
        .i_wr_en   (w_wr_en),
        .i_wr_data (DataIn),
        .i_rd_en   (Pop),
        .o_rd_data (DataOut),
        .o_empty   (Empty),
        .o_full    (w_full),
        .o_count   (Count)
    );

    assign Full      = w_full;
    assign Ack       = r_ack;
    assign BlockDone = r_block_done;

endmodule

// File: tb/tb_receiver.sv
// Directed self-checking bench for the four-phase link receiver.
module tb_receiver;

    logic        clk;
    logic        Reset;
    logic        Request;
    logic [15:0] DataIn;
    logic        Ack;
    logic        Pop;
    logic [15:0] DataOut;
    logic        Empty;
    logic        Full;
    logic [4:0]  Count;
    logic        BlockDone;

    int n_cmp;
    int n_bad;
    int bd_seen;

    receiver dut (
        .clk       (clk),
        .Reset     (Reset),
        .Request   (Request),
        .DataIn    (DataIn),
        .Ack       (Ack),
        .Pop       (Pop),
        .DataOut   (DataOut),
        .Empty     (Empty),
        .Full      (Full),
        .Count     (Count),
        .BlockDone (BlockDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (BlockDone === 1'b1) bd_seen++;
    endtask

    task automatic send(input logic [15:0] w);
        Request = 1'b1;
        DataIn  = w;
        for (int i = 0; i < 20 && Ack !== 1'b1; i++) tick();
        chk("send_ack_high", 32'(Ack), 32'd1);
        Request = 1'b0;
        for (int i = 0; i < 20 && Ack !== 1'b0; i++) tick();
        chk("send_ack_low", 32'(Ack), 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; bd_seen = 0;
        Reset = 1'b1; Request = 1'b0; DataIn = 16'h0000; Pop = 1'b0;
        #3;
        chk("rst_ack",   32'(Ack),       32'd0);
        chk("rst_count", 32'(Count),     32'd0);
        chk("rst_empty", 32'(Empty),     32'd1);
        chk("rst_full",  32'(Full),      32'd0);
        chk("rst_dout",  32'(DataOut),   32'd0);
        chk("rst_bd",    32'(BlockDone), 32'd0);
        tick(); tick();
        Reset = 1'b0;

        // Single word
        Request = 1'b1; DataIn = 16'hA5A5;
        tick();
        chk("w1_ack_not_yet", 32'(Ack),   32'd0);
        chk("w1_count",       32'(Count), 32'd1);
        tick();
        chk("w1_ack",   32'(Ack),     32'd1);
        chk("w1_empty", 32'(Empty),   32'd0);
        chk("w1_dout",  32'(DataOut), 32'h0000A5A5);
        Request = 1'b0;
        tick();
        chk("w1_ack_drop", 32'(Ack), 32'd0);

        // Long Request: exactly one write
        Pop = 1'b1; tick(); Pop = 1'b0;
        chk("pop1_count", 32'(Count), 32'd0);
        Request = 1'b1; DataIn = 16'h0001;
        repeat (10) tick();
        chk("long_count", 32'(Count),   32'd1);
        chk("long_ack",   32'(Ack),     32'd1);
        chk("long_dout",  32'(DataOut), 32'h00000001);
        Request = 1'b0;
        tick();
        chk("long_ack_drop", 32'(Ack),   32'd0);
        chk("long_count2",   32'(Count), 32'd1);

        // Full block from a clean reset
        Reset = 1'b1; #1; tick(); Reset = 1'b0;
        bd_seen = 0;
        for (int i = 0; i < 16; i++) send(16'(i));
        chk("blk_pulses", 32'(bd_seen),   32'd1);
        chk("blk_bd_low", 32'(BlockDone), 32'd0);
        chk("blk_full",   32'(Full),      32'd1);
        chk("blk_count",  32'(Count),     32'd16);
        chk("blk_dout",   32'(DataOut),   32'h00000000);
        Request = 1'b1; DataIn = 16'h0010;
        repeat (3) tick();
        chk("w17_ack",   32'(Ack),   32'd0);
        chk("w17_count", 32'(Count), 32'd16);
        chk("w17_full",  32'(Full),  32'd1);

        // Backpressure release
        Pop = 1'b1; tick(); Pop = 1'b0;
        chk("bp_count15", 32'(Count),   32'd15);
        chk("bp_dout0",   32'(DataOut), 32'h00000000);
        chk("bp_full0",   32'(Full),    32'd0);
        tick();
        chk("bp_count16", 32'(Count),   32'd16);
        chk("bp_dout1",   32'(DataOut), 32'h00000001);
        chk("bp_ack0",    32'(Ack),     32'd0);
        tick();
        chk("bp_ack1", 32'(Ack), 32'd1);
        Request = 1'b0;
        tick();
        chk("bp_ack_drop", 32'(Ack), 32'd0);

        // Drain to three entries: 0x000E, 0x000F, 0x0010
        Pop = 1'b1; repeat (13) tick(); Pop = 1'b0;
        tick();
        chk("dr_count", 32'(Count),   32'd3);
        chk("dr_dout",  32'(DataOut), 32'h0000000E);

        // Simultaneous write and pop
        Request = 1'b1; DataIn = 16'h0011; Pop = 1'b1;
        tick();
        Pop = 1'b0;
        chk("sim_count", 32'(Count), 32'd3);
        tick();
        chk("sim_dout", 32'(DataOut), 32'h0000000F);
        chk("sim_ack",  32'(Ack),     32'd1);
        Request = 1'b0;
        tick();
        chk("sim_ack_drop", 32'(Ack), 32'd0);
        Pop = 1'b1; tick(); Pop = 1'b0; tick();
        chk("ord_dout10", 32'(DataOut), 32'h00000010);
        chk("ord_count2", 32'(Count),   32'd2);
        Pop = 1'b1; tick(); Pop = 1'b0; tick();
        chk("ord_dout11", 32'(DataOut), 32'h00000011);
        Pop = 1'b1; tick(); Pop = 1'b0;
        chk("ord_empty", 32'(Empty), 32'd1);
        tick();
        chk("ord_hold", 32'(DataOut), 32'h00000011);

        // Pop while empty is ignored
        Pop = 1'b1; tick(); Pop = 1'b0;
        chk("pe_count", 32'(Count), 32'd0);
        chk("pe_empty", 32'(Empty), 32'd1);
        tick();
        chk("pe_dout", 32'(DataOut), 32'h00000011);

        // Reset in WAIT_DROP with five words stored
        for (int i = 1; i <= 4; i++) send(16'(32 + i));
        Request = 1'b1; DataIn = 16'h0ABC;
        tick(); tick();
        chk("wd_ack",   32'(Ack),   32'd1);
        chk("wd_count", 32'(Count), 32'd5);
        #1 Reset = 1'b1;
        #1;
        chk("wd_rst_ack",   32'(Ack),     32'd0);
        chk("wd_rst_count", 32'(Count),   32'd0);
        chk("wd_rst_empty", 32'(Empty),   32'd1);
        chk("wd_rst_dout",  32'(DataOut), 32'd0);
        tick();
        Reset = 1'b0;
        tick();
        chk("re_count", 32'(Count), 32'd1);
        chk("re_ack0",  32'(Ack),   32'd0);
        tick();
        chk("re_ack1", 32'(Ack),     32'd1);
        chk("re_dout", 32'(DataOut), 32'h00000ABC);
        Request = 1'b0;
        tick();
        chk("re_ack_drop", 32'(Ack), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
